dmem_arbiter: RTL and testbench

//   Shares the single data-memory port (dmem_wrapper) between two requesters:

---
 rtl/dmem_arbiter_if.sv | 26 ++
 rtl/dmem_arbiter.sv | 120 ++++++++++++
 tb/tb_dmem_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Requester-side bundle for the data-memory arbiter.
// master = requester (CPU MEM / debug loader), slave = arbiter.
interface dmem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [2:0]    op;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;
  logic          err;

  modport master (
    output req, we, addr, wdata, op,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, addr, wdata, op,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter for the single data-memory port.
// One access per three cycles: IDLE (grant) -> ACCESS -> RESP.
module dmem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          resetn,
  dmem_arbiter_if.slave m0,
  dmem_arbiter_if.slave m1,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [2:0]    mem_op,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_adel,
  input  logic          mem_ades
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_live;
  logic          r_sel;
  logic          r_rr_last;
  logic          r_we;
  logic          r_err;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [2:0]    r_op;

  logic          w_take;
  logic          w_pick;
  logic          w_gnt0;
  logic          w_gnt1;
  logic          w_rv0;
  logic          w_rv1;
  logic          w_mem_we;
  logic [DW-1:0] w_rdata;

  always_comb begin
    w_next   = r_state;
    w_take   = 1'b0;
    w_pick   = 1'b0;
    w_gnt0   = 1'b0;
    w_gnt1   = 1'b0;
    w_rv0    = 1'b0;
    w_rv1    = 1'b0;
    w_mem_we = 1'b0;
    w_rdata  = '0;
    unique case (r_state)
      S_IDLE: begin
        // r_live keeps grants quiet until the first edge after reset
        w_take = r_live & (m0.req | m1.req);
        w_pick = (m0.req & m1.req) ? ~r_rr_last : m1.req;
        w_gnt0 = w_take & ~w_pick;
        w_gnt1 = w_take & w_pick;
        if (w_take) w_next = S_ACCESS;
      end
      S_ACCESS: begin
        w_mem_we = r_we & ~mem_ades;
        w_next   = S_RESP;
      end
      S_RESP: begin
        w_rv0   = ~r_sel;
        w_rv1   = r_sel;
        w_rdata = (r_we | r_err) ? '0 : mem_rdata;
        w_next  = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_live    <= 1'b0;
      r_sel     <= 1'b0;
      r_rr_last <= 1'b1;
      r_we      <= 1'b0;
      r_err     <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_op      <= 3'b000;
    end else begin
      r_state <= w_next;
      r_live  <= 1'b1;
      if (w_take) begin
        r_sel     <= w_pick;
        r_rr_last <= w_pick;
        r_we      <= w_pick ? m1.we    : m0.we;
        r_addr    <= w_pick ? m1.addr  : m0.addr;
        r_wdata   <= w_pick ? m1.wdata : m0.wdata;
        r_op      <= w_pick ? m1.op    : m0.op;
      end
      if (r_state == S_ACCESS)
        r_err <= mem_adel | mem_ades;
    end
  end

  assign mem_we    = w_mem_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_op    = r_op;

  assign m0.gnt    = w_gnt0;
  assign m1.gnt    = w_gnt1;
  assign m0.rvalid = w_rv0;
  assign m1.rvalid = w_rv1;
  assign m0.rdata  = w_rv0 ? w_rdata : '0;
  assign m1.rdata  = w_rv1 ? w_rdata : '0;
  assign m0.err    = w_rv0 & r_err;
  assign m1.err    = w_rv1 & r_err;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: byte-array BRAM environment plus an
// independent reference memory and round-robin model.
module tb_dmem_arbiter;

  logic        clk;
  logic        resetn;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_op;
  logic [31:0] mem_rdata;
  logic        mem_adel;
  logic        mem_ades;
  logic        acc_we;

  dmem_arbiter_if m0_if ();
  dmem_arbiter_if m1_if ();

  dmem_arbiter dut (
    .clk       (clk),
    .resetn    (resetn),
    .m0        (m0_if),
    .m1        (m1_if),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_op    (mem_op),
    .mem_rdata (mem_rdata),
    .mem_adel  (mem_adel),
    .mem_ades  (mem_ades)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int rr_last = 1;

  logic [7:0]  bram [256];
  logic [7:0]  rmem [256];
  bit          q_req   [2];
  bit          q_we    [2];
  logic [31:0] q_addr  [2];
  logic [31:0] q_wdata [2];
  logic [2:0]  q_op    [2];

  function automatic bit misal(input logic [2:0] op, input logic [31:0] a);
    case (op)
      3'b000:                return a[1:0] != 2'b00;
      3'b001, 3'b100, 3'b101: return a[0];
      default:               return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] fmt(input logic [2:0] op,
                                      input logic [31:0] a,
                                      input logic [31:0] w);
    logic [31:0] s;
    s = w >> {a[1:0], 3'b000};
    case (op)
      3'b100:  return {{16{s[15]}}, s[15:0]};
      3'b101:  return {16'h0, s[15:0]};
      3'b110:  return {{24{s[7]}}, s[7:0]};
      3'b111:  return {24'h0, s[7:0]};
      default: return w;
    endcase
  endfunction

  function automatic int nbytes(input logic [2:0] op);
    return (op == 3'b010) ? 1 : (op == 3'b001) ? 2 : 4;
  endfunction

  function automatic logic [7:0] sbase(input logic [2:0] op,
                                       input logic [31:0] a);
    return (op == 3'b000) ? {a[7:2], 2'b00} : a[7:0];
  endfunction

  // Environment: synchronous BRAM with combinational alignment checks
  always @(posedge clk) begin
    logic [7:0] b;
    logic [31:0] w;
    b = {mem_addr[7:2], 2'b00};
    w = {bram[b + 8'd3], bram[b + 8'd2], bram[b + 8'd1], bram[b]};
    mem_rdata <= fmt(mem_op, mem_addr, w);
    if (mem_we)
      for (int i = 0; i < nbytes(mem_op); i++)
        bram[sbase(mem_op, mem_addr) + 8'(i)] <= mem_wdata[8*i +: 8];
    if (m0_if.gnt) acc_we <= m0_if.we;
    else if (m1_if.gnt) acc_we <= m1_if.we;
  end

  assign mem_adel = misal(mem_op, mem_addr) & ~acc_we;
  assign mem_ades = misal(mem_op, mem_addr) & acc_we;

  task automatic put();
    m0_if.req = q_req[0]; m0_if.we = q_we[0]; m0_if.addr = q_addr[0];
    m0_if.wdata = q_wdata[0]; m0_if.op = q_op[0];
    m1_if.req = q_req[1]; m1_if.we = q_we[1]; m1_if.addr = q_addr[1];
    m1_if.wdata = q_wdata[1]; m1_if.op = q_op[1];
  endtask

  task automatic setp(input int p, input bit rq, input bit we,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic [2:0] op);
    q_req[p] = rq; q_we[p] = we; q_addr[p] = a;
    q_wdata[p] = d; q_op[p] = op;
  endtask

  // One transaction from IDLE; called just after a rising edge.
  task automatic txn(input bit drop);
    int exp_w, w, waited;
    bit mis;
    logic [31:0] er, rw, gv0, gv1;
    logic [7:0] b;
    exp_w = (q_req[0] && q_req[1]) ? 1 - rr_last :
            q_req[0] ? 0 : q_req[1] ? 1 : -1;
    w = -1;
    waited = 0;
    while (w < 0 && waited < 6) begin
      @(negedge clk);
      if (m0_if.gnt) w = 0;
      else if (m1_if.gnt) w = 1;
      if (w < 0) begin
        @(posedge clk); #1;
        waited++;
      end
    end
    n_chk++;
    if (w != exp_w) begin
      n_fail++;
      $display("FAIL gnt_winner: got %0d want %0d", w, exp_w);
    end
    if (w < 0) return;
    n_chk++;
    if ({m0_if.gnt, m1_if.gnt, mem_we, m0_if.rvalid, m1_if.rvalid} !==
        {w == 0, w == 1, 3'b000}) begin
      n_fail++;
      $display("FAIL idle_outs: gnt0=%b gnt1=%b we=%b rv=%b%b",
               m0_if.gnt, m1_if.gnt, mem_we, m0_if.rvalid, m1_if.rvalid);
    end
    mis = misal(q_op[w], q_addr[w]);
    er = 32'h0;
    if (!mis && q_we[w]) begin
      for (int i = 0; i < nbytes(q_op[w]); i++)
        rmem[sbase(q_op[w], q_addr[w]) + 8'(i)] = q_wdata[w][8*i +: 8];
    end else if (!mis) begin
      b = {q_addr[w][7:2], 2'b00};
      rw = {rmem[b + 8'd3], rmem[b + 8'd2], rmem[b + 8'd1], rmem[b]};
      er = fmt(q_op[w], q_addr[w], rw);
    end
    rr_last = w;
    @(posedge clk); #1;
    if (drop) begin
      q_req[w] = 1'b0;
      put();
    end
    @(negedge clk);
    n_chk++;
    if ({mem_we, mem_addr, mem_op} !==
        {q_we[w] & ~mis, q_addr[w], q_op[w]}) begin
      n_fail++;
      $display("FAIL access: we=%b addr=%h op=%b want we=%b addr=%h op=%b",
               mem_we, mem_addr, mem_op, q_we[w] & ~mis, q_addr[w], q_op[w]);
    end
    n_chk++;
    if ({m0_if.gnt, m1_if.gnt, m0_if.rvalid, m1_if.rvalid} !== 4'b0) begin
      n_fail++;
      $display("FAIL access_quiet: gnt=%b%b rv=%b%b want 0",
               m0_if.gnt, m1_if.gnt, m0_if.rvalid, m1_if.rvalid);
    end
    @(posedge clk); #1;
    @(negedge clk);
    gv0 = (w == 0) ? er : 32'h0;
    gv1 = (w == 1) ? er : 32'h0;
    n_chk++;
    if ({m0_if.rvalid, m1_if.rvalid, m0_if.err, m1_if.err, mem_we} !==
        {w == 0, w == 1, mis & (w == 0), mis & (w == 1), 1'b0}) begin
      n_fail++;
      $display("FAIL resp_flags: rv=%b%b err=%b%b we=%b want port %0d err %b",
               m0_if.rvalid, m1_if.rvalid, m0_if.err, m1_if.err, mem_we,
               w, mis);
    end
    n_chk++;
    if (m0_if.rdata !== gv0 || m1_if.rdata !== gv1) begin
      n_fail++;
      $display("FAIL resp_rdata: got %h/%h want %h/%h",
               m0_if.rdata, m1_if.rdata, gv0, gv1);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    setp(0, 1'b1, 1'b0, 32'h10, 32'h0, 3'b000);
    setp(1, 1'b1, 1'b0, 32'h14, 32'h0, 3'b000);
    put();
    repeat (2) @(negedge clk);
    n_chk++;
    if ({m0_if.gnt, m1_if.gnt, m0_if.rvalid, m1_if.rvalid, m0_if.err,
         m1_if.err, mem_we, mem_op} !== 10'b0 ||
        {m0_if.rdata, m1_if.rdata, mem_addr, mem_wdata} !== 128'b0) begin
      n_fail++;
      $display("FAIL reset_outs: gnt=%b%b rv=%b%b we=%b op=%b addr=%h",
               m0_if.gnt, m1_if.gnt, m0_if.rvalid, m1_if.rvalid, mem_we,
               mem_op, mem_addr);
    end
    q_req[0] = 1'b0; q_req[1] = 1'b0;
    put();
    resetn = 1'b1;
    rr_last = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_read_word;
    setp(0, 1'b1, 1'b0, 32'h10, 32'h0, 3'b000);
    put();
    txn(1'b1);
  endtask

  task automatic test_store_byte;
    setp(1, 1'b1, 1'b1, 32'h23, 32'h000000AB, 3'b010);
    put();
    txn(1'b1);
    setp(1, 1'b1, 1'b0, 32'h23, 32'h0, 3'b111);
    put();
    txn(1'b1);
  endtask

  task automatic test_round_robin;
    setp(0, 1'b1, 1'b0, 32'h10, 32'h0, 3'b000);
    setp(1, 1'b1, 1'b0, 32'h22, 32'h0, 3'b100);
    put();
    repeat (4) txn(1'b0);
    q_req[0] = 1'b0; q_req[1] = 1'b0;
    put();
  endtask

  task automatic test_misaligned;
    setp(0, 1'b1, 1'b1, 32'h6, 32'hDEADBEEF, 3'b000);
    put();
    txn(1'b1);
    setp(1, 1'b1, 1'b0, 32'h5, 32'h0, 3'b100);
    put();
    txn(1'b1);
    setp(1, 1'b1, 1'b0, 32'h4, 32'h0, 3'b000);
    put();
    txn(1'b1);
  endtask

  task automatic test_reset_mid;
    setp(0, 1'b1, 1'b1, 32'h40, 32'hCAFEF00D, 3'b000);
    q_req[1] = 1'b0;
    put();
    @(negedge clk);
    n_chk++;
    if (m0_if.gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_gnt: got %b want 1", m0_if.gnt);
    end
    @(posedge clk); #1;
    resetn = 1'b0;
    #1;
    n_chk++;
    if ({mem_we, mem_op, mem_addr, m0_if.gnt, m0_if.rvalid} !== 38'b0) begin
      n_fail++;
      $display("FAIL rst_mid_now: we=%b op=%b addr=%h want 0",
               mem_we, mem_op, mem_addr);
    end
    setp(1, 1'b1, 1'b0, 32'h80, 32'h0, 3'b000);
    setp(0, 1'b1, 1'b0, 32'h40, 32'h0, 3'b000);
    put();
    repeat (2) begin
      @(negedge clk);
      n_chk++;
      if ({m0_if.gnt, m1_if.gnt, m0_if.rvalid, m1_if.rvalid, mem_we} !==
          5'b0) begin
        n_fail++;
        $display("FAIL rst_mid_hold: gnt=%b%b rv=%b%b we=%b want 0",
                 m0_if.gnt, m1_if.gnt, m0_if.rvalid, m1_if.rvalid, mem_we);
      end
    end
    resetn = 1'b1;
    rr_last = 1;
    @(posedge clk); #1;
    txn(1'b1);
    q_req[1] = 1'b0;
    put();
  endtask

  task automatic test_random;
    bit rq;
    logic [2:0] ops [7];
    logic [31:0] a;
    ops = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b110, 3'b111};
    for (int k = 0; k < 40; k++) begin
      for (int p = 0; p < 2; p++) begin
        if (!q_req[p] || rr_last == p) begin
          rq = $urandom_range(0, 3) != 0;
          a = 32'($urandom_range(0, 255));
          setp(p, rq, 1'b0, a, $urandom, ops[$urandom_range(0, 6)]);
          q_we[p] = (q_op[p][2] == 1'b0) && ($urandom_range(0, 1) == 1);
          if ($urandom_range(0, 4) != 0) begin
            if (q_op[p] == 3'b000) q_addr[p][1:0] = 2'b00;
            else q_addr[p][0] = 1'b0;
          end
        end
      end
      if (!q_req[0] && !q_req[1]) q_req[0] = 1'b1;
      put();
      txn($urandom_range(0, 1) == 1);
    end
    q_req[0] = 1'b0; q_req[1] = 1'b0;
    put();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      bram[i] = 8'(i * 7 + 3);
      rmem[i] = 8'(i * 7 + 3);
    end
    {bram[19], bram[18], bram[17], bram[16]} = 32'h11223344;
    {rmem[19], rmem[18], rmem[17], rmem[16]} = 32'h11223344;
    acc_we = 1'b0;
    resetn = 1'b0;
    for (int p = 0; p < 2; p++) setp(p, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    put();
    #1;
    test_reset();
    test_read_word();
    test_store_byte();
    test_round_robin();
    test_misaligned();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
